// File: rtl/dmem_banked_port.sv
// rtl/dmem_banked_port.sv - byte-banked data memory with split misaligned access
//
// Purpose: LSU-facing data memory made of BANKS byte-wide banks. An access
// that fits in one row takes one beat. An access that crosses a row boundary
// takes two beats, on row and on row+1, and stalls the port for one cycle.
// Loads are aligned, merged and sign/zero extended into a registered response.
//
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_req_valid / o_req_ready  request handshake
//   i_req_write                1 = store, 0 = load
//   i_req_addr                 byte address
//   i_req_size                 log2 of the access size in bytes
//   i_req_unsigned             zero-extend loads when set
//   i_req_wdata                right-justified store data
//   o_rsp_valid                one-cycle response pulse
//   o_rsp_rdata                right-justified, extended load data (0 for stores)
module dmem_banked_port #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata
);

  localparam int BANKS = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BANKS);
  localparam int ROW_W = ADDR_WIDTH - OFF_W;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t                  state;
  logic [7:0]              mem [BANKS][DEPTH];

  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [1:0]              lat_size;
  logic                    lat_unsigned;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   hold;

  logic                    beat1;
  logic                    fire;
  logic                    cur_write;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [1:0]              cur_size;
  logic                    cur_unsigned;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [1:0]              in_size;
  logic [OFF_W-1:0]        cur_off;
  logic [ROW_W-1:0]        beat_row;
  logic [4:0]              nbytes;
  logic [4:0]              end_byte;
  logic                    misaligned;
  logic [BANKS-1:0]        we;
  logic [DATA_WIDTH-1:0]   wbytes;
  logic [DATA_WIDTH-1:0]   rd_row;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   loaded;
  logic                    sign;
  logic [OFF_W-1:0]        widx;
  logic                    in_range;

  always_comb begin
    // A dword request on a 32-bit memory degrades to a word access.
    in_size      = (DATA_WIDTH == 32 && i_req_size == 2'd3) ? 2'd2 : i_req_size;
    beat1        = (state == SECOND);
    cur_write    = beat1 ? lat_write    : i_req_write;
    cur_addr     = beat1 ? lat_addr     : i_req_addr;
    cur_size     = beat1 ? lat_size     : in_size;
    cur_unsigned = beat1 ? lat_unsigned : i_req_unsigned;
    cur_wdata    = beat1 ? lat_wdata    : i_req_wdata;
    fire         = i_rst_n && (beat1 || (o_req_ready && i_req_valid));

    cur_off    = cur_addr[OFF_W-1:0];
    nbytes     = 5'd1 << cur_size;
    end_byte   = 5'(cur_off) + nbytes;
    misaligned = end_byte > 5'(BANKS);
    // Row counter wraps silently from DEPTH-1 to 0.
    beat_row   = cur_addr[ADDR_WIDTH-1:OFF_W] + (beat1 ? ROW_W'(1) : ROW_W'(0));

    we     = '0;
    wbytes = '0;
    rd_row = '0;
    for (int b = 0; b < BANKS; b++) begin
      rd_row[8*b +: 8] = mem[b][beat_row];
      // Beat 0 covers off..end, beat 1 covers the spill-over from bank 0.
      in_range = beat1 ? (5'(b) < end_byte - 5'(BANKS))
                       : (5'(b) >= 5'(cur_off) && 5'(b) < end_byte);
      we[b] = fire && cur_write && in_range;
      // Data byte index is (b - off) mod BANKS; OFF_W-bit arithmetic does the mod.
      widx = OFF_W'(b) - cur_off;
      wbytes[8*b +: 8] = cur_wdata[8*widx +: 8];
    end

    // Beat-1 row sits above the held beat-0 row, so one shift aligns both cases.
    shifted = DATA_WIDTH'((beat1 ? {rd_row, hold} : {{DATA_WIDTH{1'b0}}, rd_row})
                          >> {cur_off, 3'b000});

    sign   = 1'b0;
    loaded = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (5'(i) == nbytes - 5'd1) sign = shifted[8*i+7];
      loaded[8*i +: 8] = (5'(i) < nbytes) ? shifted[8*i +: 8]
                                          : {8{sign && !cur_unsigned}};
    end
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (we[b]) mem[b][beat_row] <= wbytes[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!beat1 && o_req_ready && i_req_valid && misaligned) begin
      lat_write    <= i_req_write;
      lat_addr     <= i_req_addr;
      lat_size     <= in_size;
      lat_unsigned <= i_req_unsigned;
      lat_wdata    <= i_req_wdata;
      hold         <= rd_row;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_rsp_valid <= 1'b0;
          if (i_req_valid) begin
            if (misaligned) begin
              state       <= SECOND;
              o_req_ready <= 1'b0;
            end else begin
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= cur_write ? '0 : loaded;
            end
          end
        end
        SECOND: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b1;
          o_rsp_rdata <= cur_write ? '0 : loaded;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_banked_port.md
# dmem_banked_port

Byte-banked, parametrised data memory with a valid/ready request port and a registered response. It is the next generation of the core's data memory. It adds:
- configurable data width and depth;
- load alignment with sign/zero extension;
- hardware splitting of misaligned accesses into two row beats.

It sits between the LSU and the on-chip SRAM banks.

## Interface
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64; BANKS = DATA_WIDTH/8 byte banks
- DEPTH, 1024, rows per bank; power of two
- ADDR_WIDTH, 12, byte address width; must equal log2(DEPTH) + log2(BANKS)
- i_clk  in  1  clock; all state updates on posedge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid && ready at posedge
- i_req_write  in  1  1 = store, 0 = load
- i_req_addr  in  ADDR_WIDTH  byte address
- i_req_size  in  2  0 byte, 1 half, 2 word, 3 dword (3 legal only when DATA_WIDTH=64)
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- i_req_wdata  in  DATA_WIDTH  store data, right-justified
- o_rsp_valid  out  1  one-cycle response pulse; no backpressure
- o_rsp_rdata  out  DATA_WIDTH  load data, right-justified and extended; 0 for stores

## Operation
**Address decode**
- off = addr[log2(BANKS)-1:0]
- row = addr[ADDR_WIDTH-1:log2(BANKS)]
- nbytes = 1 << size

**Access classes**
- Aligned: off + nbytes ≤ BANKS. One beat on row.
- Misaligned: otherwise. Two beats:
  - beat 0: row, banks off..BANKS-1
  - beat 1: (row+1) mod DEPTH, banks 0..(off+nbytes-BANKS-1)
  - Row wrap from DEPTH-1 to 0 is silent; it is not an error.

**Stores**
- Bank b is written iff b is within the beat's byte range.
- Written byte is wdata byte (b - off) mod BANKS.
- Other banks are untouched.

**Loads**
- Every bank of the beat's row is read into a registered output.
- Beat-0 bytes are captured into a hold register for the merge.
- Merged bytes are right-shifted by off and masked to nbytes.
- Sign extension uses bit 8*nbytes-1 unless i_req_unsigned. A dword load with DATA_WIDTH=64 needs no extension.

**FSM**
- IDLE: o_req_ready=1. A misaligned request is accepted → SECOND. An aligned request stays in IDLE.
- SECOND: o_req_ready=0. Beat 1 executes using latched addr/size/unsigned/wdata/write → IDLE.
- A response is produced exactly once per accepted request.

**Other rules**
- Memory contents are not reset and are undefined until written.
- Reset (i_rst_n=0 at posedge):
  - state→IDLE, o_rsp_valid→0, o_rsp_rdata→0, o_req_ready→1 in the first cycle after reset.
  - A pending beat 1 is dropped. A beat-0 store already committed stays committed.
  - No response is issued for the interrupted request.
- Illegal size 3 with DATA_WIDTH=32 is treated as size 2.

## Timing
- Aligned request accepted at edge T: memory access at T; o_rsp_valid=1 with data in the cycle after T (latency 1).
- Misaligned request accepted at T: beat 1 at T+1; response in the cycle after T+1 (latency 2). o_req_ready is low for one cycle.
- Back-to-back aligned requests sustain 1 request/cycle with o_req_ready held high.
- A store followed by a load to the same byte on the next cycle returns the new data, because the write commits at the store's edge.
- o_rsp_valid is never high two cycles for one request.

## Test plan
- Aligned word: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp 1 cycle after each accept, rdata 0xDEADBEEF; back-to-back with ready constantly 1.
- Byte extension: SB 0x80 @0x21; LB @0x21 → 0xFFFFFF80; LBU → 0x00000080; LH @0x20 (byte 0x20 = 0x11) → 0xFFFF8011; neighbouring bytes unchanged.
- Misaligned: SW 0x44332211 @0x03 → rows 0/1 bank bytes written; ready low 1 cycle; LW @0x03 → 0x44332211 after latency 2; LBU @0x04 → 0x22.
- Wrap: LW @(2^ADDR_WIDTH - 2) after writing bytes 0xAA,0xBB there and 0xCC,0xDD @0x0 → 0xDDCCBBAA.
- Reset mid-op: assert i_rst_n=0 during SECOND of a misaligned SW → no rsp, ready=1 next cycle, beat-0 bytes written, beat-1 bytes unchanged.
- DATA_WIDTH=64 instance: SD/LD 0x0123456789ABCDEF @0x8 and misaligned LD @0x5 returning the correct merged bytes.
